// File: rtl/board_cursor_if.sv
// board_cursor_if: button inputs and cursor/fire outputs of the board cursor controller
//   master: button side (drives enable, btn_*_n; observes cursor/fire outputs)
//   slave : controller side (consumes buttons; drives cur_x/y, moved, fire_pulse, fire_x/y)
interface board_cursor_if #(
    parameter int COORD_W = 4
);
    logic               enable;
    logic               btn_up_n;
    logic               btn_down_n;
    logic               btn_left_n;
    logic               btn_right_n;
    logic               btn_fire_n;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               moved;
    logic               fire_pulse;
    logic [COORD_W-1:0] fire_x;
    logic [COORD_W-1:0] fire_y;

    modport master (
        output enable, btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_fire_n,
        input  cur_x, cur_y, moved, fire_pulse, fire_x, fire_y
    );

    modport slave (
        input  enable, btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_fire_n,
        output cur_x, cur_y, moved, fire_pulse, fire_x, fire_y
    );
endinterface

// File: rtl/board_cursor_ctrl.sv
// board_cursor_ctrl: turns debounced active-low buttons into a wrapping board cursor with auto-repeat and fire capture
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : enable, btn_{up,down,left,right,fire}_n in; cur_x/y, moved, fire_pulse, fire_x/y out
module board_cursor_ctrl #(
    parameter int BOARD_W       = 10,
    parameter int BOARD_H       = 10,
    parameter int COORD_W       = 4,
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic          clk,
    input  logic          rst_n,
    board_cursor_if.slave bus
);
    localparam int MAXD  = HOLD_DELAY > REPEAT_PERIOD ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(MAXD);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0]   REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [COORD_W-1:0] MAX_X     = COORD_W'(BOARD_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y     = COORD_W'(BOARD_H - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t             state, state_nxt;
    dir_t               dir, dir_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [4:0]         btn_n, prev_n, press;
    logic [3:0]         dir_btn_n;
    logic               step, fire_ev;
    logic [COORD_W-1:0] cx, cy, x_nxt, y_nxt, fx, fy;
    logic               mv, fp;

    // bit order {fire, right, left, down, up}; also the direction priority order (LSB wins)
    assign btn_n     = {bus.btn_fire_n, bus.btn_right_n, bus.btn_left_n, bus.btn_down_n, bus.btn_up_n};
    assign dir_btn_n = btn_n[3:0];
    assign press     = prev_n & ~btn_n;
    assign fire_ev   = bus.enable & press[4];

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        step      = 1'b0;
        if (!bus.enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            if (|press[3:0]) begin
                dir_nxt   = press[0] ? D_UP : press[1] ? D_DOWN : press[2] ? D_LEFT : D_RIGHT;
                step      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = HOLD;
            end
        end else if (dir_btn_n[dir]) begin
            // selected button released; other directions never re-arm until IDLE
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (cnt == (state == HOLD ? HOLD_LAST : REP_LAST)) begin
            step      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = REPEAT;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        x_nxt = !step ? cx :
                dir_nxt == D_LEFT  ? (cx == '0    ? MAX_X : cx - 1'b1) :
                dir_nxt == D_RIGHT ? (cx == MAX_X ? '0    : cx + 1'b1) : cx;
        y_nxt = !step ? cy :
                dir_nxt == D_UP    ? (cy == '0    ? MAX_Y : cy - 1'b1) :
                dir_nxt == D_DOWN  ? (cy == MAX_Y ? '0    : cy + 1'b1) : cy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dir    <= D_UP;
            cnt    <= '0;
            prev_n <= '0;
            cx     <= '0;
            cy     <= '0;
            fx     <= '0;
            fy     <= '0;
            mv     <= 1'b0;
            fp     <= 1'b0;
        end else begin
            state  <= state_nxt;
            dir    <= dir_nxt;
            cnt    <= cnt_nxt;
            prev_n <= btn_n;
            cx     <= x_nxt;
            cy     <= y_nxt;
            mv     <= step;
            fp     <= fire_ev;
            if (fire_ev) begin
                fx <= cx;
                fy <= cy;
            end
        end
    end

    assign bus.cur_x      = cx;
    assign bus.cur_y      = cy;
    assign bus.moved      = mv;
    assign bus.fire_pulse = fp;
    assign bus.fire_x     = fx;
    assign bus.fire_y     = fy;
endmodule

// File: tb/tb_board_cursor_ctrl.sv
// tb_board_cursor_ctrl: directed scoreboard bench for board_cursor_ctrl (10x10 board, HOLD_DELAY=8, REPEAT_PERIOD=4)
module tb_board_cursor_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] ex = '0, ey = '0, efx = '0, efy = '0;

    typedef struct {
        string      tag;
        logic [3:0] x, y, fx, fy;
        logic       mv, fp;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    board_cursor_if #(.COORD_W(4)) bus ();

    board_cursor_ctrl #(
        .BOARD_W(10), .BOARD_H(10), .COORD_W(4), .HOLD_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check();
        exp_t e;
        logic [17:0] o, x;
        e = q.pop_front();
        o = {bus.cur_x, bus.cur_y, bus.fire_x, bus.fire_y, bus.moved, bus.fire_pulse};
        x = {e.x, e.y, e.fx, e.fy, e.mv, e.fp};
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed x=%0d y=%0d fx=%0d fy=%0d mv=%b fp=%b expected x=%0d y=%0d fx=%0d fy=%0d mv=%b fp=%b",
                   e.tag, bus.cur_x, bus.cur_y, bus.fire_x, bus.fire_y, bus.moved, bus.fire_pulse,
                   e.x, e.y, e.fx, e.fy, e.mv, e.fp);
        end
    endtask

    task automatic now(input string tag, input logic mv, input logic fp);
        exp_t e;
        e.tag = tag;
        e.x = ex; e.y = ey; e.fx = efx; e.fy = efy;
        e.mv = mv; e.fp = fp;
        q.push_back(e);
        check();
    endtask

    task automatic tick(input string tag, input logic mv, input logic fp);
        @(posedge clk);
        #1;
        now(tag, mv, fp);
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.btn_up_n = 1'b1; bus.btn_down_n = 1'b1; bus.btn_left_n = 1'b1;
        bus.btn_right_n = 1'b1; bus.btn_fire_n = 1'b1;
        @(posedge clk); #1;
        now("reset", 0, 0);
        rst_n = 1'b1;
        tick("idle0", 0, 0);
        tick("idle1", 0, 0);

        // 1: RIGHT tap
        bus.btn_right_n = 1'b0; ex = 1;
        tick("right_step", 1, 0);
        tick("right_held", 0, 0);
        bus.btn_right_n = 1'b1;
        tick("right_rel", 0, 0);
        tick("right_idle", 0, 0);

        // 2: UP held, wrap 0->9 then auto-repeat
        bus.btn_up_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) ey = 9;
            else if (i == 9) ey = 8;
            else if (i == 13) ey = 7;
            else if (i == 17) ey = 6;
            tick("up_hold", (i == 1 || i == 9 || i == 13 || i == 17), 0);
        end
        bus.btn_up_n = 1'b1;
        for (int i = 0; i < 6; i++) tick("up_rel", 0, 0);

        // walk to (9,5)
        bus.btn_left_n = 1'b0; ex = 0; tick("left_to0", 1, 0);
        bus.btn_left_n = 1'b1; tick("left_rel", 0, 0);
        bus.btn_left_n = 1'b0; ex = 9; tick("left_wrap", 1, 0);
        bus.btn_left_n = 1'b1; tick("left_rel2", 0, 0);
        bus.btn_up_n = 1'b0; ey = 5; tick("up_to5", 1, 0);
        bus.btn_up_n = 1'b1; tick("up_rel2", 0, 0);

        // 3: RIGHT wrap and FIRE on the same edge, FIRE held
        bus.btn_right_n = 1'b0; bus.btn_fire_n = 1'b0;
        ex = 0; efx = 9; efy = 5;
        tick("right_fire", 1, 1);
        bus.btn_right_n = 1'b1;
        for (int i = 0; i < 20; i++) tick("fire_held", 0, 0);
        bus.btn_fire_n = 1'b1;
        tick("fire_rel", 0, 0);

        // 4: UP and LEFT together, UP wins; LEFT held after UP release does nothing
        bus.btn_up_n = 1'b0; bus.btn_left_n = 1'b0; ey = 4;
        tick("up_left", 1, 0);
        for (int i = 0; i < 4; i++) tick("both_held", 0, 0);
        bus.btn_up_n = 1'b1;
        for (int i = 0; i < 4; i++) tick("left_only", 0, 0);
        bus.btn_left_n = 1'b1; tick("left_rel3", 0, 0);
        bus.btn_left_n = 1'b0; ex = 9; tick("left_again", 1, 0);
        bus.btn_left_n = 1'b1; tick("left_rel4", 0, 0);

        // 5: DOWN held through reset release
        bus.btn_down_n = 1'b0;
        rst_n = 1'b0;
        #1;
        ex = 0; ey = 0; efx = 0; efy = 0;
        now("reset2", 0, 0);
        tick("in_reset", 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("down_thru_rst", 0, 0);
        bus.btn_down_n = 1'b1; tick("down_rel", 0, 0);
        bus.btn_down_n = 1'b0; ey = 1; tick("down_step", 1, 0);
        for (int i = 2; i <= 11; i++) begin
            if (i == 9) ey = 2;
            tick("down_hold", i == 9, 0);
        end
        // asynchronous reset while in REPEAT
        #2;
        rst_n = 1'b0;
        #1;
        ey = 0;
        now("async_rst", 0, 0);
        bus.btn_down_n = 1'b1;
        rst_n = 1'b1;
        tick("post_rst", 0, 0);

        // 6: set up nonzero cursor and fire capture, then enable=0
        bus.btn_right_n = 1'b0; ex = 1; tick("r_a", 1, 0);
        bus.btn_right_n = 1'b1; tick("r_a_rel", 0, 0);
        bus.btn_down_n = 1'b0; ey = 1; tick("d_a", 1, 0);
        bus.btn_down_n = 1'b1; tick("d_a_rel", 0, 0);
        bus.btn_fire_n = 1'b0; efx = 1; efy = 1; tick("fire_a", 0, 1);
        bus.btn_fire_n = 1'b1; tick("fire_a_rel", 0, 0);
        bus.btn_right_n = 1'b0; ex = 2; tick("r_b", 1, 0);
        bus.btn_right_n = 1'b1; tick("r_b_rel", 0, 0);
        bus.enable = 1'b0;
        bus.btn_right_n = 1'b0; bus.btn_fire_n = 1'b0; bus.btn_down_n = 1'b0;
        for (int i = 0; i < 3; i++) tick("disabled", 0, 0);
        bus.btn_right_n = 1'b1; bus.btn_fire_n = 1'b1;
        tick("disabled_rel", 0, 0);
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) tick("enable_held", 0, 0);
        bus.btn_down_n = 1'b1; tick("down_rel2", 0, 0);
        bus.btn_down_n = 1'b0; ey = 2; tick("down_after_en", 1, 0);
        bus.btn_down_n = 1'b1; tick("down_rel3", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
